// File: rtl/scan_shift_counter.sv
// One-hot scanning shift register with bounce/rotate patterns, runtime prescaler
// and optional end-of-travel dwell in bounce mode.
module scan_shift_counter #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 8,
  parameter int DWELL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] div,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             step,
  output logic             end_hit
);

  typedef enum logic [1:0] {
    MODE_BOUNCE = 2'b00,
    MODE_ROT_L  = 2'b01,
    MODE_ROT_R  = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  localparam int DWELL_W = (DWELL > 0) ? $clog2(DWELL + 1) : 1;
  localparam logic [DWELL_W-1:0] DWELL_L = DWELL_W'(DWELL);

  mode_e mode_s;

  logic [WIDTH-1:0]   count_q, count_d;
  logic               dir_q, dir_d;
  logic               step_q, step_d;
  logic               end_hit_q, end_hit_d;
  logic [DIV_W-1:0]   presc_q, presc_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;

  logic               run;
  logic               tick;
  logic [WIDTH-1:0]   shl, shr, rotl, rotr;

  assign mode_s = mode_e'(mode);
  assign run    = en && (mode_s != MODE_HOLD);

  assign shl  = {count_q[WIDTH-2:0], 1'b0};
  assign shr  = {1'b0, count_q[WIDTH-1:1]};
  assign rotl = {count_q[WIDTH-2:0], count_q[WIDTH-1]};
  assign rotr = {count_q[0], count_q[WIDTH-1:1]};

  // Prescaler: ">=" lets a reduced divisor take effect on the next enabled cycle.
  always_comb begin
    presc_d = presc_q;
    tick    = 1'b0;
    if (load) begin
      presc_d = '0;
    end else if (run) begin
      if (presc_q >= div) begin
        presc_d = '0;
        tick    = 1'b1;
      end else begin
        presc_d = presc_q + DIV_W'(1);
      end
    end
  end

  always_comb begin
    count_d   = count_q;
    dir_d     = dir_q;
    step_d    = 1'b0;
    end_hit_d = 1'b0;
    dwell_d   = dwell_q;

    if (mode_s != MODE_BOUNCE) begin
      dwell_d = '0;
    end

    if (load) begin
      count_d = load_val;
      dwell_d = '0;
    end else if (tick) begin
      unique case (mode_s)
        MODE_BOUNCE: begin
          if (count_q == '0) begin
            // Recover from an empty pattern by restarting at the LSB.
            count_d = WIDTH'(1);
            dir_d   = 1'b1;
            step_d  = 1'b1;
          end else if (dir_q) begin
            if (!count_q[WIDTH-1]) begin
              count_d   = shl;
              step_d    = 1'b1;
              end_hit_d = shl[WIDTH-1];
            end else if (dwell_q != DWELL_L) begin
              dwell_d = dwell_q + DWELL_W'(1);
            end else begin
              count_d   = shr;
              dir_d     = 1'b0;
              dwell_d   = '0;
              step_d    = 1'b1;
              end_hit_d = shr[0];
            end
          end else begin
            if (!count_q[0]) begin
              count_d   = shr;
              step_d    = 1'b1;
              end_hit_d = shr[0];
            end else if (dwell_q != DWELL_L) begin
              dwell_d = dwell_q + DWELL_W'(1);
            end else begin
              count_d   = shl;
              dir_d     = 1'b1;
              dwell_d   = '0;
              step_d    = 1'b1;
              end_hit_d = shl[WIDTH-1];
            end
          end
        end
        MODE_ROT_L: begin
          count_d   = rotl;
          dir_d     = 1'b1;
          step_d    = 1'b1;
          end_hit_d = count_q[WIDTH-1];
        end
        MODE_ROT_R: begin
          count_d   = rotr;
          dir_d     = 1'b0;
          step_d    = 1'b1;
          end_hit_d = count_q[0];
        end
        default: begin
          count_d = count_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q   <= WIDTH'(1);
      dir_q     <= 1'b1;
      step_q    <= 1'b0;
      end_hit_q <= 1'b0;
      presc_q   <= '0;
      dwell_q   <= '0;
    end else begin
      count_q   <= count_d;
      dir_q     <= dir_d;
      step_q    <= step_d;
      end_hit_q <= end_hit_d;
      presc_q   <= presc_d;
      dwell_q   <= dwell_d;
    end
  end

  assign count   = count_q;
  assign dir     = dir_q;
  assign step    = step_q;
  assign end_hit = end_hit_q;

endmodule

// File: tb/tb_scan_shift_counter.sv
// Randomised bench for scan_shift_counter: two instances (no dwell / dwell of 2)
// checked every cycle against an arithmetic model, plus literal sequence checks.
module tb_scan_shift_counter;

  logic       clk;
  logic       reset;
  logic       en;
  logic [1:0] mode;
  logic [3:0] div;
  logic       load;
  logic [3:0] load_val;

  logic [3:0] count0, count1;
  logic       dir0, dir1, step0, step1, eh0, eh1;

  int nvec  = 0;
  int nfail = 0;
  bit cmp_on = 0;

  scan_shift_counter #(.WIDTH(4), .DIV_W(4), .DWELL(0)) u0 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .div(div),
    .load(load), .load_val(load_val),
    .count(count0), .dir(dir0), .step(step0), .end_hit(eh0)
  );

  scan_shift_counter #(.WIDTH(4), .DIV_W(4), .DWELL(2)) u1 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .div(div),
    .load(load), .load_val(load_val),
    .count(count1), .dir(dir1), .step(step1), .end_hit(eh1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] cnt;
    logic       dir;
    logic [3:0] presc;
    logic [1:0] dwell;
    logic       step;
    logic       eh;
  } mst_t;

  mst_t ms0, ms1;

  function automatic mst_t mreset();
    mst_t r;
    r.cnt = 4'd1; r.dir = 1'b1; r.presc = 4'd0; r.dwell = 2'd0;
    r.step = 1'b0; r.eh = 1'b0;
    return r;
  endfunction

  // Pattern treated as an integer 0..15: doubling moves toward the MSB, halving toward the LSB.
  function automatic mst_t mnext(mst_t s, int dmax, logic en_v, logic [1:0] md,
                                 logic [3:0] dv, logic ld, logic [3:0] lv);
    mst_t r;
    int   c, n;
    bit   tick;
    r = s; r.step = 1'b0; r.eh = 1'b0; tick = 0;
    c = int'(s.cnt);
    n = c;
    if (md != 2'd0) r.dwell = 2'd0;
    if (ld) begin
      r.cnt = lv; r.presc = 4'd0; r.dwell = 2'd0;
      return r;
    end
    if (en_v && md != 2'd3) begin
      if (s.presc >= dv) begin r.presc = 4'd0; tick = 1; end
      else r.presc = s.presc + 4'd1;
    end
    if (!tick) return r;
    case (md)
      2'd0: begin
        if (c == 0) begin
          n = 1; r.dir = 1'b1; r.step = 1'b1;
        end else if (s.dir) begin
          if (c < 8) begin n = c * 2; r.step = 1'b1; r.eh = (n >= 8); end
          else if (int'(s.dwell) < dmax) r.dwell = s.dwell + 2'd1;
          else begin n = c / 2; r.dir = 1'b0; r.dwell = 2'd0; r.step = 1'b1; r.eh = (n % 2 == 1); end
        end else begin
          if (c % 2 == 0) begin n = c / 2; r.step = 1'b1; r.eh = (n % 2 == 1); end
          else if (int'(s.dwell) < dmax) r.dwell = s.dwell + 2'd1;
          else begin n = (c * 2) % 16; r.dir = 1'b1; r.dwell = 2'd0; r.step = 1'b1; r.eh = (n >= 8); end
        end
      end
      2'd1: begin
        n = (c * 2) % 16 + c / 8; r.dir = 1'b1; r.step = 1'b1; r.eh = (c >= 8);
      end
      default: begin
        n = c / 2 + (c % 2) * 8; r.dir = 1'b0; r.step = 1'b1; r.eh = (c % 2 == 1);
      end
    endcase
    r.cnt = 4'(n);
    return r;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      ms0 <= mreset();
      ms1 <= mreset();
    end else begin
      ms0 <= mnext(ms0, 0, en, mode, div, load, load_val);
      ms1 <= mnext(ms1, 2, en, mode, div, load, load_val);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("u0.count",   int'(count0), int'(ms0.cnt));
      chk("u0.dir",     int'(dir0),   int'(ms0.dir));
      chk("u0.step",    int'(step0),  int'(ms0.step));
      chk("u0.end_hit", int'(eh0),    int'(ms0.eh));
      chk("u1.count",   int'(count1), int'(ms1.cnt));
      chk("u1.dir",     int'(dir1),   int'(ms1.dir));
      chk("u1.step",    int'(step1),  int'(ms1.step));
      chk("u1.end_hit", int'(eh1),    int'(ms1.eh));
    end
  end

  // Counts rising edges until u0 shows a step; -1 on timeout.
  task automatic wait_step(output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (step0) begin n = i; return; end
    end
    n = -1;
  endtask

  int exp_c0 [7] = '{2, 4, 8, 4, 2, 1, 2};
  int exp_d0 [7] = '{1, 1, 1, 0, 0, 0, 1};
  int exp_e0 [7] = '{0, 0, 1, 0, 0, 1, 0};
  int exp_c1 [7] = '{2, 4, 8, 8, 8, 4, 2};
  int exp_d1 [7] = '{1, 1, 1, 1, 1, 0, 0};
  int exp_s1 [7] = '{1, 1, 1, 0, 0, 1, 1};

  initial begin
    int n;
    int r;
    reset = 1'b0; en = 1'b0; mode = 2'd0; div = 4'd0; load = 1'b0; load_val = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset.count", int'(count0), 1);
    chk("reset.dir",   int'(dir0),   1);
    chk("reset.step",  int'(step0),  0);
    chk("reset.eh",    int'(eh0),    0);
    cmp_on = 1;

    // Bounce sequence from reset, no dwell and dwell of 2
    @(posedge clk); #1;
    reset = 1'b1; en = 1'b1; mode = 2'd0; div = 4'd0;
    @(negedge clk);
    chk("seq.first", int'(count0), 1);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk($sformatf("seq0.count[%0d]", i), int'(count0), exp_c0[i]);
      chk($sformatf("seq0.dir[%0d]", i),   int'(dir0),   exp_d0[i]);
      chk($sformatf("seq0.eh[%0d]", i),    int'(eh0),    exp_e0[i]);
      chk($sformatf("seq1.count[%0d]", i), int'(count1), exp_c1[i]);
      chk($sformatf("seq1.dir[%0d]", i),   int'(dir1),   exp_d1[i]);
      chk($sformatf("seq1.step[%0d]", i),  int'(step1),  exp_s1[i]);
    end

    // Prescaler div=2 and enable freeze
    div = 4'd2;
    wait_step(n); chk("div2.gap1", n, 3);
    wait_step(n); chk("div2.gap2", n, 3);
    @(posedge clk); #1 en = 1'b0;
    repeat (5) @(posedge clk);
    #1 en = 1'b1;
    wait_step(n); chk("div2.freeze_gap", n, 2);

    // Rotations of a multi-hot pattern
    @(negedge clk);
    div = 4'd0; mode = 2'd1; load = 1'b1; load_val = 4'b0101;
    @(posedge clk); #1 load = 1'b0;
    @(negedge clk);
    chk("rotl.load.count", int'(count0), 5);
    chk("rotl.load.step",  int'(step0),  0);
    @(negedge clk);
    chk("rotl.c1", int'(count0), 10); chk("rotl.e1", int'(eh0), 0);
    @(negedge clk);
    chk("rotl.c2", int'(count0), 5);  chk("rotl.e2", int'(eh0), 1);
    @(negedge clk);
    chk("rotl.c3", int'(count0), 10); chk("rotl.e3", int'(eh0), 0);
    mode = 2'd2;
    @(negedge clk);
    chk("rotr.c1", int'(count0), 5);  chk("rotr.e1", int'(eh0), 0);
    chk("rotr.dir", int'(dir0), 0);
    @(negedge clk);
    chk("rotr.c2", int'(count0), 10); chk("rotr.e2", int'(eh0), 1);

    // Load zero in bounce, then load colliding with a tick
    mode = 2'd0; load = 1'b1; load_val = 4'd0;
    @(posedge clk); #1 load = 1'b0;
    @(negedge clk);
    chk("zero.count", int'(count0), 0);
    @(negedge clk);
    chk("zero.recover.count", int'(count0), 1);
    chk("zero.recover.dir",   int'(dir0),   1);
    chk("zero.recover.step",  int'(step0),  1);
    chk("zero.recover.eh",    int'(eh0),    0);
    load = 1'b1; load_val = 4'b0010;
    @(posedge clk); #1 load = 1'b0;
    @(negedge clk);
    chk("loadwin.count", int'(count0), 2);
    chk("loadwin.step",  int'(step0),  0);

    // Asynchronous reset between clock edges
    div = 4'd1;
    repeat (5) @(negedge clk);
    @(posedge clk); #2 reset = 1'b0;
    #1;
    chk("areset.u0.count", int'(count0), 1);
    chk("areset.u0.dir",   int'(dir0),   1);
    chk("areset.u1.count", int'(count1), 1);
    chk("areset.u1.step",  int'(step1),  0);
    #1 reset = 1'b1;
    wait_step(n); chk("areset.first_step", n, 2);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      en = ($urandom % 8) != 0;
      if ($urandom % 24 == 0) begin
        r = int'($urandom % 8);
        mode = (r < 4) ? 2'd0 : 2'(r % 4);
      end
      if ($urandom % 40 == 0) div = 4'($urandom % 4);
      load = ($urandom % 24) == 0;
      load_val = 4'($urandom);
      if ($urandom % 300 == 0) begin
        #1 reset = 1'b0;
        #1 reset = 1'b1;
      end
    end
    @(negedge clk);
    cmp_on = 0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
